// File: rtl/seven_seg_reader.sv
// Receive-side decoder for a multiplexed 4-digit seven-segment bus: synchronizes
// seg/an, waits for a stable pattern, and latches the hex value of each digit.
module seven_seg_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic        digit_stb,
  output logic        bad_pattern,
  output logic        frame_done
);

  typedef enum logic [1:0] {IDLE, COUNT, HELD} state_t;

  localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);

  // {ok, value}: ok = 1 only for one of the sixteen hex glyphs
  function automatic logic [4:0] decode_seg(input logic [6:0] p);
    case (p)
      7'h3F: return {1'b1, 4'h0};
      7'h06: return {1'b1, 4'h1};
      7'h5B: return {1'b1, 4'h2};
      7'h4F: return {1'b1, 4'h3};
      7'h66: return {1'b1, 4'h4};
      7'h6D: return {1'b1, 4'h5};
      7'h7D: return {1'b1, 4'h6};
      7'h07: return {1'b1, 4'h7};
      7'h7F: return {1'b1, 4'h8};
      7'h6F: return {1'b1, 4'h9};
      7'h77: return {1'b1, 4'hA};
      7'h7C: return {1'b1, 4'hB};
      7'h39: return {1'b1, 4'hC};
      7'h5E: return {1'b1, 4'hD};
      7'h79: return {1'b1, 4'hE};
      7'h71: return {1'b1, 4'hF};
      default: return 5'b0;
    endcase
  endfunction

  logic [6:0]  seg_s1_q, seg_s2_q;
  logic [3:0]  an_s1_q, an_s2_q;
  logic [10:0] prev_q, prev_d;
  logic [7:0]  cnt_q, cnt_d;
  state_t      state_q, state_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  valid_q, valid_d;
  logic        stb_q, stb_d;
  logic        bad_q, bad_d;
  logic        frame_q, frame_d;
  logic [3:0]  seen_q, seen_d;

  logic [10:0] s_cur;
  logic        onehot;
  logic [1:0]  idx;
  logic        latch;
  logic [4:0]  dec;
  logic [3:0]  seen_nx;

  assign s_cur = {an_s2_q, seg_s2_q};
  assign dec   = decode_seg(seg_s2_q);

  always_comb begin
    onehot = 1'b1;
    idx    = 2'd0;
    case (an_s2_q)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: onehot = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    digits_d = digits_q;
    valid_d  = valid_q;
    seen_d   = seen_q;
    stb_d    = 1'b0;
    bad_d    = 1'b0;
    frame_d  = 1'b0;
    prev_d   = s_cur;
    latch    = 1'b0;
    seen_nx  = seen_q | an_s2_q;

    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (onehot) begin
          state_d = COUNT;
          cnt_d   = 8'd1;
        end
      end
      COUNT: begin
        if (!onehot) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (s_cur == prev_q) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == STABLE_LIM) begin
            latch   = 1'b1;
            state_d = HELD;
          end
        end else begin
          cnt_d = 8'd1;
        end
      end
      HELD: begin
        if (s_cur != prev_q) begin
          state_d = onehot ? COUNT : IDLE;
          cnt_d   = onehot ? 8'd1 : 8'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    // Blank and hex glyphs count toward the frame; invalid glyphs only flag
    if (latch) begin
      if (dec[4] || seg_s2_q == 7'h00) begin
        digits_d[{idx, 2'b00} +: 4] = dec[4] ? dec[3:0] : 4'h0;
        valid_d[idx]                = dec[4];
        stb_d                       = 1'b1;
        if (seen_nx == 4'hF) begin
          frame_d = 1'b1;
          seen_d  = 4'h0;
        end else begin
          seen_d = seen_nx;
        end
      end else begin
        bad_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q <= '0;
      seg_s2_q <= '0;
      an_s1_q  <= '0;
      an_s2_q  <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
      state_q  <= IDLE;
      digits_q <= '0;
      valid_q  <= '0;
      stb_q    <= 1'b0;
      bad_q    <= 1'b0;
      frame_q  <= 1'b0;
      seen_q   <= '0;
    end else begin
      seg_s1_q <= seg;
      seg_s2_q <= seg_s1_q;
      an_s1_q  <= an;
      an_s2_q  <= an_s1_q;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      stb_q    <= stb_d;
      bad_q    <= bad_d;
      frame_q  <= frame_d;
      seen_q   <= seen_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign digit_stb   = stb_q;
  assign bad_pattern = bad_q;
  assign frame_done  = frame_q;

endmodule

// File: tb/tb_seven_seg_reader.sv
// Directed bench for seven_seg_reader: table of held patterns with expected
// register state and pulse counts, plus hand sequences for latency and reset.
module tb_seven_seg_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg = '0;
  logic [3:0]  an = '0;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        digit_stb, bad_pattern, frame_done;

  seven_seg_reader #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .an(an),
    .digits(digits), .digit_valid(digit_valid), .digit_stb(digit_stb),
    .bad_pattern(bad_pattern), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    int          n;
    logic [15:0] dig;
    logic [3:0]  vld;
    int          stb;
    int          bad;
    int          frm;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;
  int stb_n, bad_n, frm_n, orphan_n;
  vec_t vecs[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one clock edge, then sample pulses away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (digit_stb) stb_n++;
    if (bad_pattern) bad_n++;
    if (frame_done) frm_n++;
    if (frame_done && !digit_stb) orphan_n++;
  endtask

  task automatic clr_counts();
    stb_n = 0; bad_n = 0; frm_n = 0;
  endtask

  initial begin
    orphan_n = 0;
    clr_counts();
    vecs[0]  = '{4'b0001, 7'h3F, 8,  16'h0000, 4'b0001, 1, 0, 0};
    vecs[1]  = '{4'b0010, 7'h5B, 8,  16'h0020, 4'b0011, 1, 0, 0};
    vecs[2]  = '{4'b0100, 7'h4F, 8,  16'h0320, 4'b0111, 1, 0, 0};
    vecs[3]  = '{4'b1000, 7'h66, 8,  16'h4320, 4'b1111, 1, 0, 1};
    vecs[4]  = '{4'b0001, 7'h7F, 3,  16'h4320, 4'b1111, 0, 0, 0};
    vecs[5]  = '{4'b0001, 7'h06, 8,  16'h4321, 4'b1111, 1, 0, 0};
    vecs[6]  = '{4'b0010, 7'h49, 8,  16'h4321, 4'b1111, 0, 1, 0};
    vecs[7]  = '{4'b0010, 7'h00, 8,  16'h4301, 4'b1101, 1, 0, 0};
    vecs[8]  = '{4'b0011, 7'h7F, 20, 16'h4301, 4'b1101, 0, 0, 0};
    vecs[9]  = '{4'b0100, 7'h77, 8,  16'h4A01, 4'b1101, 1, 0, 0};
    vecs[10] = '{4'b1000, 7'h79, 8,  16'hEA01, 4'b1101, 1, 0, 1};
    vecs[11] = '{4'b0010, 7'h71, 8,  16'hEAF1, 4'b1111, 1, 0, 0};
    vecs[12] = '{4'b0000, 7'h00, 6,  16'hEAF1, 4'b1111, 0, 0, 0};
    vecs[13] = '{4'b0001, 7'h7C, 8,  16'hEAFB, 4'b1111, 1, 0, 0};
    vecs[14] = '{4'b0100, 7'h5E, 8,  16'hEDFB, 4'b1111, 1, 0, 0};
    vecs[15] = '{4'b1000, 7'h39, 8,  16'hCDFB, 4'b1111, 1, 0, 1};
    vecs[16] = '{4'b0001, 7'h6D, 8,  16'hCDF5, 4'b1111, 1, 0, 0};
    vecs[17] = '{4'b0010, 7'h07, 8,  16'hCD75, 4'b1111, 1, 0, 0};
    vecs[18] = '{4'b0100, 7'h7D, 8,  16'hC675, 4'b1111, 1, 0, 0};
    vecs[19] = '{4'b1000, 7'h6F, 8,  16'h9675, 4'b1111, 1, 0, 1};
    vecs[20] = '{4'b0001, 7'h7F, 8,  16'h9678, 4'b1111, 1, 0, 0};
    vecs[21] = '{4'b0010, 7'h7F, 8,  16'h9688, 4'b1111, 1, 0, 0};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_digits", 32'(digits), 32'h0);
    chk("rst_valid", 32'(digit_valid), 32'h0);
    chk("rst_pulses", {29'b0, digit_stb, bad_pattern, frame_done}, 32'h0);
    rst_n = 1'b1;
    tick();
    tick();

    // first-latch latency: latch exactly on the 6th edge after the pin change
    an = 4'b0001; seg = 7'h06;
    clr_counts();
    for (int e = 1; e <= 5; e++) tick();
    chk("lat_no_early_stb", 32'(stb_n), 32'd0);
    tick();
    chk("lat_stb_edge6", 32'(digit_stb), 32'd1);
    chk("lat_digit0", 32'(digits[3:0]), 32'd1);
    chk("lat_valid", 32'(digit_valid), 32'b0001);
    for (int e = 0; e < 4; e++) tick();
    chk("lat_single_stb", 32'(stb_n), 32'd1);

    for (int v = 0; v < 22; v++) begin
      an = vecs[v].an; seg = vecs[v].seg;
      clr_counts();
      for (int c = 0; c < vecs[v].n; c++) tick();
      chk($sformatf("v%0d_digits", v), 32'(digits), 32'(vecs[v].dig));
      chk($sformatf("v%0d_valid", v), 32'(digit_valid), 32'(vecs[v].vld));
      chk($sformatf("v%0d_stb", v), 32'(stb_n), 32'(vecs[v].stb));
      chk($sformatf("v%0d_bad", v), 32'(bad_n), 32'(vecs[v].bad));
      chk($sformatf("v%0d_frame", v), 32'(frm_n), 32'(vecs[v].frm));
    end
    chk("frame_with_stb", 32'(orphan_n), 32'd0);

    // reset while counter = 3 on a pending latch
    an = 4'b0100; seg = 7'h06;
    clr_counts();
    for (int e = 0; e < 5; e++) tick();
    chk("pre_rst_no_stb", 32'(stb_n), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_digits", 32'(digits), 32'h0);
    chk("async_rst_valid", 32'(digit_valid), 32'h0);
    clr_counts();
    tick();
    tick();
    chk("in_rst_pulses", 32'(stb_n + bad_n + frm_n), 32'd0);
    rst_n = 1'b1;
    for (int e = 1; e <= 5; e++) tick();
    chk("post_rst_no_early", 32'(stb_n), 32'd0);
    tick();
    chk("post_rst_stb", 32'(digit_stb), 32'd1);
    chk("post_rst_digits", 32'(digits), 32'h0100);
    chk("post_rst_valid", 32'(digit_valid), 32'b0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
